dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
Issue controller between the dual-slot IF/ID pipeline register and the ID/EX stage of the 2-wide core. It inspects the fetched instruction pair and decides whether both slots issue together, issue serially over two cycles, or wait for a load-use bubble. It drives the stall and flush controls back to the PC and IF/ID register. It also registers the per-lane issue outputs (instruction plus valid) toward decode/ID-EX.

Parameters:
MEM_SPLIT, 1, 1 = a pair containing two memory ops (load/store) is split because there is a single data-memory port.
BR_SPLIT, 1, 1 = a branch in slot 1 forces split issue.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_instr1  in  32  slot-1 instruction from IF/ID (older)
id_instr2  in  32  slot-2 instruction from IF/ID (younger)
id_valid  in  1  IF/ID pair is valid
ex_load1  in  1  ID/EX lane 1 holds a load
ex_load_rd1  in  5  dest reg of ID/EX lane-1 load
ex_load2  in  1  ID/EX lane 2 holds a load
ex_load_rd2  in  5  dest reg of ID/EX lane-2 load
branch_taken  in  1  taken branch resolved in EX
if_stall  out  1  hold PC and IF/ID (combinational)
if_flush  out  1  clear IF/ID (combinational, = branch_taken)
issue_instr1  out  32  lane-1 instruction (registered)
issue_instr2  out  32  lane-2 instruction (registered)
issue_valid1  out  1  lane 1 valid (registered)
issue_valid2  out  1  lane 2 valid (registered)
state_o  out  1  0 = PAIR, 1 = SECOND

Behaviour:
- Fields: op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11]. The all-zero word is a NOP: no dest, no sources.
- dest(i): rd if op = 0; rt if op is 100011 (lw), 001000, 001100, 001101 or 001010; otherwise none. A dest of r0 counts as none.
- srcs(i): rs for any non-NOP. rt additionally for op 0, 101011 (sw) and 000100 (beq).
- mem(i): op is 100011 or 101011. br(i): op is 000100.
- lu(i): some source of i is nonzero and equals ex_load_rdN with ex_loadN = 1, for either lane N.
- split: any of the following.
  - dest(i1) is nonzero and is in srcs(i2) (RAW).
  - dest(i1) = dest(i2), nonzero (WAW).
  - MEM_SPLIT and mem(i1) and mem(i2).
  - BR_SPLIT and br(i1).
- Reset: state = PAIR; issue_instr1/2 = 0; issue_valid1/2 = 0. if_stall = 0 and if_flush = 0 while in reset.
- A bubble means issue_valid = 0 and issue_instr = 0 on that lane.
- Priority each cycle: reset > branch_taken > id_valid = 0 > hazard rules.
- branch_taken (any state): if_flush = 1, if_stall = 0, both lanes bubble, next state = PAIR. Any pending slot 2 is dropped.
- id_valid = 0: both lanes bubble, if_stall = 0, state unchanged.
- PAIR state:
  - lu(i1): if_stall = 1, both lanes bubble, stay in PAIR.
  - else if split or lu(i2): issue i1 on lane 1, lane 2 bubble, if_stall = 1, go to SECOND.
  - else: issue i1 on lane 1 and i2 on lane 2, if_stall = 0, stay in PAIR.
- SECOND state (IF/ID still holds the same pair because of the stall):
  - lu(i2): if_stall = 1, both lanes bubble, stay in SECOND.
  - else: lane 1 bubble, issue i2 on lane 2, if_stall = 0, go to PAIR.
- Latency: issue_* reflect the decision one clock after it is evaluated. if_stall/if_flush act in the same cycle.
- Program order is never violated. Lane 2 never issues ahead of lane 1 for the same pair.

Test Plan:
- Independent pair: i1 = 0x00221820 (add r3,r1,r2), i2 = 0x00E83020 (add r6,r7,r8), id_valid = 1 -> next cycle both lanes valid with those words; if_stall = 0 throughout.
- RAW split: i1 = 0x00221820, i2 = 0x00652020 (add r4,r3,r5).
  - Cycle 0: if_stall = 1 and issue_instr1 = 0x00221820, valid = 10.
  - Cycle 1: issue_instr2 = 0x00652020, valid = 01, state back to PAIR.
- Memory split: i1 = 0x8C230000 (lw r3,0(r1)), i2 = 0xAC450004 (sw r5,4(r2)) -> split into two cycles, exactly as in the RAW case.
- Load-use: ex_load1 = 1, ex_load_rd1 = 1, i1 = 0x00221820.
  - Cycle 0: if_stall = 1, valid = 00.
  - Cycle 1, with ex_load1 dropped to 0: both lanes issue.
- Flush in SECOND: after the RAW split cycle 0, assert branch_taken -> if_flush = 1, valid = 00, state = PAIR, and 0x00652020 never issues.
- Reset mid-SECOND: assert reset in SECOND -> state = PAIR, all issue outputs = 0, if_stall = 0 on the following cycle.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - dual-slot issue controller: pair/split/load-use stall decisions and registered lane outputs
module dual_issue_scheduler #(
    parameter bit MEM_SPLIT = 1'b1,
    parameter bit BR_SPLIT  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr1,
    input  logic [31:0] id_instr2,
    input  logic        id_valid,
    input  logic        ex_load1,
    input  logic [4:0]  ex_load_rd1,
    input  logic        ex_load2,
    input  logic [4:0]  ex_load_rd2,
    input  logic        branch_taken,
    output logic        if_stall,
    output logic        if_flush,
    output logic [31:0] issue_instr1,
    output logic [31:0] issue_instr2,
    output logic        issue_valid1,
    output logic        issue_valid2,
    output logic        state_o
);
    typedef enum logic {PAIR = 1'b0, SECOND = 1'b1} state_t;

    state_t      state, state_next;
    logic [31:0] instr1_next, instr2_next;
    logic        valid1_next, valid2_next;
    logic [4:0]  dest1, dest2;
    logic        lu1, lu2, split;

    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        case (ins[31:26])
            6'b000000:                                         dest_of = ins[15:11];
            6'b100011, 6'b001000, 6'b001100, 6'b001101, 6'b001010: dest_of = ins[20:16];
            default:                                           dest_of = 5'd0;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [31:0] ins);
        reads_rt = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b101011) ||
                   (ins[31:26] == 6'b000100);
    endfunction

    // True when register r (never r0) is a source operand of ins; the NOP reads nothing.
    function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
        reads_reg = (r != 5'd0) && (ins != 32'd0) &&
                    ((ins[25:21] == r) || (reads_rt(ins) && (ins[20:16] == r)));
    endfunction

    function automatic logic is_mem(input logic [31:0] ins);
        is_mem = (ins[31:26] == 6'b100011) || (ins[31:26] == 6'b101011);
    endfunction

    always_comb begin
        dest1 = dest_of(id_instr1);
        dest2 = dest_of(id_instr2);
        lu1   = (ex_load1 && reads_reg(id_instr1, ex_load_rd1)) ||
                (ex_load2 && reads_reg(id_instr1, ex_load_rd2));
        lu2   = (ex_load1 && reads_reg(id_instr2, ex_load_rd1)) ||
                (ex_load2 && reads_reg(id_instr2, ex_load_rd2));
        split = reads_reg(id_instr2, dest1) ||
                ((dest1 != 5'd0) && (dest1 == dest2)) ||
                (MEM_SPLIT && is_mem(id_instr1) && is_mem(id_instr2)) ||
                (BR_SPLIT && (id_instr1[31:26] == 6'b000100));
    end

    always_comb begin
        state_next  = state;
        if_stall    = 1'b0;
        if_flush    = 1'b0;
        instr1_next = 32'd0;
        instr2_next = 32'd0;
        valid1_next = 1'b0;
        valid2_next = 1'b0;
        if (reset) begin
            state_next = PAIR;
        end else if (branch_taken) begin
            if_flush   = 1'b1;
            state_next = PAIR;
        end else if (id_valid) begin
            case (state)
                PAIR: begin
                    if (lu1) begin
                        if_stall = 1'b1;
                    end else if (split || lu2) begin
                        instr1_next = id_instr1;
                        valid1_next = 1'b1;
                        if_stall    = 1'b1;
                        state_next  = SECOND;
                    end else begin
                        instr1_next = id_instr1;
                        valid1_next = 1'b1;
                        instr2_next = id_instr2;
                        valid2_next = 1'b1;
                    end
                end
                SECOND: begin
                    // IF/ID is frozen on the same pair; only the younger slot remains.
                    if (lu2) begin
                        if_stall = 1'b1;
                    end else begin
                        instr2_next = id_instr2;
                        valid2_next = 1'b1;
                        state_next  = PAIR;
                    end
                end
                default: state_next = PAIR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PAIR;
            issue_instr1 <= 32'd0;
            issue_instr2 <= 32'd0;
            issue_valid1 <= 1'b0;
            issue_valid2 <= 1'b0;
        end else begin
            state        <= state_next;
            issue_instr1 <= instr1_next;
            issue_instr2 <= instr2_next;
            issue_valid1 <= valid1_next;
            issue_valid2 <= valid2_next;
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - directed plus randomized check of dual_issue_scheduler against a behavioural model
module tb_dual_issue_scheduler;
    logic        clk = 1'b0;
    logic        reset, id_valid, ex_load1, ex_load2, branch_taken;
    logic [31:0] id_instr1, id_instr2;
    logic [4:0]  ex_load_rd1, ex_load_rd2;
    logic        if_stall, if_flush, issue_valid1, issue_valid2, state_o;
    logic [31:0] issue_instr1, issue_instr2;

    int nvec = 0;
    int nerr = 0;

    logic        m_second = 1'b0;
    logic [31:0] m_i1 = 32'd0, m_i2 = 32'd0;
    logic        m_v1 = 1'b0, m_v2 = 1'b0;
    logic        m_stall_prev = 1'b0;
    logic        seen_stall, seen_flush;

    dual_issue_scheduler dut (
        .clk(clk), .reset(reset), .id_instr1(id_instr1), .id_instr2(id_instr2),
        .id_valid(id_valid), .ex_load1(ex_load1), .ex_load_rd1(ex_load_rd1),
        .ex_load2(ex_load2), .ex_load_rd2(ex_load_rd2), .branch_taken(branch_taken),
        .if_stall(if_stall), .if_flush(if_flush), .issue_instr1(issue_instr1),
        .issue_instr2(issue_instr2), .issue_valid1(issue_valid1),
        .issue_valid2(issue_valid2), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] m_dest(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'd0) return w[15:11];
        if (op == 6'h23 || op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A) return w[20:16];
        return 5'd0;
    endfunction

    // Source set of an instruction as a list; the bench asks set-membership questions of it.
    function automatic int m_reads(input logic [31:0] w, input logic [4:0] r);
        logic [4:0] s[$];
        logic [5:0] op;
        op = w[31:26];
        if (w == 32'd0 || r == 5'd0) return 0;
        s.push_back(w[25:21]);
        if (op == 6'd0 || op == 6'h2B || op == 6'h04) s.push_back(w[20:16]);
        foreach (s[k]) if (s[k] == r) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic bt, input logic v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic l1, input logic [4:0] r1,
                        input logic l2, input logic [4:0] r2);
        logic e_stall, e_flush, lua, lub, spl, n_second, n_v1, n_v2;
        logic [31:0] n_i1, n_i2;
        logic [4:0] da, db;
        reset = rst; branch_taken = bt; id_valid = v; id_instr1 = a; id_instr2 = b;
        ex_load1 = l1; ex_load_rd1 = r1; ex_load2 = l2; ex_load_rd2 = r2;
        #1;
        da  = m_dest(a);
        db  = m_dest(b);
        lua = (l1 && m_reads(a, r1) != 0) || (l2 && m_reads(a, r2) != 0);
        lub = (l1 && m_reads(b, r1) != 0) || (l2 && m_reads(b, r2) != 0);
        spl = (m_reads(b, da) != 0) || (da != 5'd0 && da == db) ||
              ((a[31:26] == 6'h23 || a[31:26] == 6'h2B) && (b[31:26] == 6'h23 || b[31:26] == 6'h2B)) ||
              (a[31:26] == 6'h04);
        e_stall = 1'b0; e_flush = 1'b0; n_second = m_second;
        n_i1 = 32'd0; n_i2 = 32'd0; n_v1 = 1'b0; n_v2 = 1'b0;
        if (rst) n_second = 1'b0;
        else if (bt) begin e_flush = 1'b1; n_second = 1'b0; end
        else if (!v) begin end
        else if (!m_second) begin
            if (lua) e_stall = 1'b1;
            else if (spl || lub) begin n_i1 = a; n_v1 = 1'b1; e_stall = 1'b1; n_second = 1'b1; end
            else begin n_i1 = a; n_v1 = 1'b1; n_i2 = b; n_v2 = 1'b1; end
        end else begin
            if (lub) e_stall = 1'b1;
            else begin n_i2 = b; n_v2 = 1'b1; n_second = 1'b0; end
        end
        seen_stall = if_stall;
        seen_flush = if_flush;
        chk("if_stall", {31'd0, if_stall}, {31'd0, e_stall});
        chk("if_flush", {31'd0, if_flush}, {31'd0, e_flush});
        @(posedge clk);
        #1;
        m_second = n_second; m_i1 = n_i1; m_i2 = n_i2; m_v1 = n_v1; m_v2 = n_v2;
        m_stall_prev = e_stall;
        chk("issue_instr1", issue_instr1, m_i1);
        chk("issue_instr2", issue_instr2, m_i2);
        chk("issue_valid", {30'd0, issue_valid1, issue_valid2}, {30'd0, m_v1, m_v2});
        chk("state_o", {31'd0, state_o}, {31'd0, m_second});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 8))
            0: return 32'd0;
            1, 2: return {6'h00, rs, rt, rd, 11'h020};
            3: return {6'h23, rs, rt, imm};
            4: return {6'h2B, rs, rt, imm};
            5: return {6'h04, rs, rt, imm};
            6: return {6'h08, rs, rt, imm};
            7: return {6'h0D, rs, rt, imm};
            default: return {6'h02, 26'($urandom)};
        endcase
    endfunction

    localparam logic [31:0] ADD1 = 32'h00221820, ADD2 = 32'h00E83020, ADD3 = 32'h00652020;
    localparam logic [31:0] LW   = 32'h8C230000, SW   = 32'hAC450004;

    initial begin
        logic [31:0] a, b;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, ADD1, ADD2, 0, 0, 0, 0);
        chk("pin reset stall", {31'd0, seen_stall}, 32'd0);
        chk("pin reset valid", {30'd0, issue_valid1, issue_valid2}, 32'd0);

        step(0, 0, 1, ADD1, ADD2, 0, 0, 0, 0);
        chk("pin indep i1", issue_instr1, ADD1);
        chk("pin indep i2", issue_instr2, ADD2);
        chk("pin indep valid", {30'd0, issue_valid1, issue_valid2}, 32'd3);

        step(0, 0, 1, ADD1, ADD3, 0, 0, 0, 0);
        chk("pin raw c0 stall", {31'd0, seen_stall}, 32'd1);
        chk("pin raw c0 i1", issue_instr1, ADD1);
        chk("pin raw c0 valid", {30'd0, issue_valid1, issue_valid2}, 32'd2);
        step(0, 0, 1, ADD1, ADD3, 0, 0, 0, 0);
        chk("pin raw c1 i2", issue_instr2, ADD3);
        chk("pin raw c1 valid", {30'd0, issue_valid1, issue_valid2}, 32'd1);
        chk("pin raw c1 state", {31'd0, state_o}, 32'd0);

        step(0, 0, 1, LW, SW, 0, 0, 0, 0);
        chk("pin mem c0 valid", {30'd0, issue_valid1, issue_valid2}, 32'd2);
        step(0, 0, 1, LW, SW, 0, 0, 0, 0);
        chk("pin mem c1 i2", issue_instr2, SW);

        step(0, 0, 1, ADD1, ADD2, 1, 5'd1, 0, 0);
        chk("pin lu c0 stall", {31'd0, seen_stall}, 32'd1);
        chk("pin lu c0 valid", {30'd0, issue_valid1, issue_valid2}, 32'd0);
        step(0, 0, 1, ADD1, ADD2, 0, 5'd1, 0, 0);
        chk("pin lu c1 valid", {30'd0, issue_valid1, issue_valid2}, 32'd3);

        step(0, 0, 1, ADD1, ADD3, 0, 0, 0, 0);
        step(0, 1, 1, ADD1, ADD3, 0, 0, 0, 0);
        chk("pin flush", {31'd0, seen_flush}, 32'd1);
        chk("pin flush valid", {30'd0, issue_valid1, issue_valid2}, 32'd0);
        chk("pin flush state", {31'd0, state_o}, 32'd0);
        step(0, 0, 1, ADD2, 32'd0, 0, 0, 0, 0);
        chk("pin flush no i2", issue_instr2, 32'd0);

        step(0, 0, 1, ADD1, ADD3, 0, 0, 0, 0);
        step(1, 0, 1, ADD1, ADD3, 0, 0, 0, 0);
        chk("pin rst state", {31'd0, state_o}, 32'd0);
        chk("pin rst instr", issue_instr1 | issue_instr2, 32'd0);
        step(0, 0, 0, ADD1, ADD3, 0, 0, 0, 0);
        chk("pin rst stall", {31'd0, seen_stall}, 32'd0);

        a = rand_instr();
        b = rand_instr();
        for (int n = 0; n < 4000; n++) begin
            if (!m_stall_prev) begin
                a = rand_instr();
                b = rand_instr();
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) != 0, a, b,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
